// File: rtl/ok_reg_bridge_pkg.sv
// Shared types and constants for the FrontPanel register bridge.
// Optional transaction counter is enabled with OK_REG_BRIDGE_TXN_COUNT_EN.
package ok_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TMO     = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_CNT_LSB = 8;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    // Counter only has to hold TIMEOUT_CYC-1, so log2 of the cycle count suffices.
    function automatic int tmoWidth(input int cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/ok_reg_bridge_tmo.sv
// Loadable down-counter with a terminal-count flag, used as the bus timeout.
module ok_reg_bridge_tmo #(
    parameter int W        = 8,
    parameter int LOAD_VAL = 254
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic dec_i,
    output logic tc_o
);

    localparam logic [W-1:0] LOAD_V = W'(LOAD_VAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_V;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ok_reg_bridge.sv
// Runs one host-triggered register transaction on a req/ack bus and reports the result.
// Define OK_REG_BRIDGE_TXN_COUNT_EN to expose a completed-transaction count in rsp_status[15:8].
module ok_reg_bridge
    import ok_reg_bridge_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [15:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic [15:0]       rsp_rdata,
    output logic [15:0]       rsp_status,
    output logic              rsp_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [15:0]       bus_rdata
);

    localparam int TMO_W = tmoWidth(TIMEOUT_CYC);

    state_t state_q;
    state_t state_d;

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              tmo_q,   tmo_d;
    logic              ovr_q,   ovr_d;

    logic       accept;
    logic       tmoTc;
    logic       busy;
    logic [7:0] cntField;

    assign accept = cmd_start && (state_q == IDLE);

    ok_reg_bridge_tmo #(
        .W        (TMO_W),
        .LOAD_VAL (TIMEOUT_CYC - 1)
    ) u_tmo (
        .clk_i   (ti_clk),
        .reset_i (reset),
        .load_i  (accept),
        .dec_i   ((state_q == REQ) && !bus_ack),
        .tc_o    (tmoTc)
    );

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_start) state_d = REQ;
            REQ:     if (bus_ack || tmoTc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req  = (state_q == REQ);
        rsp_done = (state_q == DONE);
        busy     = (state_q != IDLE);
    end

    // An ack in the terminal-count cycle wins over the timeout.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q;
        if (accept) begin
            we_d    = cmd_write;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            ovr_d   = 1'b0;
        end else if (cmd_start) begin
            ovr_d = 1'b1;
        end
        if (state_q == REQ) begin
            if (bus_ack) begin
                if (!we_q) rdata_d = bus_rdata;
                tmo_d = 1'b0;
            end else if (tmoTc) begin
                rdata_d = ERR_DATA;
                tmo_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef OK_REG_BRIDGE_TXN_COUNT_EN
    logic [7:0] txnCnt_q;

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            txnCnt_q <= 8'd0;
        end else if (state_q == DONE) begin
            txnCnt_q <= txnCnt_q + 8'd1;
        end
    end

    assign cntField = txnCnt_q;
`else
    assign cntField = 8'd0;
`endif

    always_comb begin
        rsp_status                      = '0;
        rsp_status[STAT_BUSY]           = busy;
        rsp_status[STAT_TMO]            = tmo_q;
        rsp_status[STAT_OVR]            = ovr_q;
        rsp_status[STAT_CNT_LSB +: 8]   = cntField;
    end

    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ok_reg_bridge.sv
// Self-checking bench for ok_reg_bridge: directed cases plus randomized transactions
// checked against a transaction-level model of the bridge.
module tb_ok_reg_bridge;

    localparam int          TMO = 8;
    localparam logic [15:0] ERR = 16'hDEAD;

    logic        ti_clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] rsp_rdata;
    logic [15:0] rsp_status;
    logic        rsp_done;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    logic [15:0] expRdata = '0;
    logic        expTmo   = 1'b0;
    logic        expOvr   = 1'b0;
    int          expCnt   = 0;

    ok_reg_bridge #(
        .ADDR_W      (8),
        .TIMEOUT_CYC (TMO),
        .ERR_DATA    (ERR)
    ) dut (
        .ti_clk     (ti_clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .rsp_done   (rsp_done),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expStatus(input bit busy);
        logic [7:0] cnt;
`ifdef OK_REG_BRIDGE_TXN_COUNT_EN
        cnt = 8'(expCnt % 256);
`else
        cnt = 8'd0;
`endif
        return {cnt, 5'b0, expOvr, expTmo, busy};
    endfunction

    function automatic int reqCyclesFor(input int ackDelay);
        return (ackDelay < TMO) ? ackDelay + 1 : TMO;
    endfunction

    task automatic modelReset();
        expRdata = '0;
        expTmo   = 1'b0;
        expOvr   = 1'b0;
        expCnt   = 0;
    endtask

    // extraAt >= 0: spurious start in that REQ cycle; -2: spurious start in DONE; -1: none.
    // ackDelay >= TMO means the user logic never acknowledges.
    task automatic applyStimulus(input bit we, input logic [7:0] addr, input logic [15:0] wd,
                                 input int ackDelay, input logic [15:0] rd, input int extraAt);
        int  nReq;
        bit  acked;
        nReq  = reqCyclesFor(ackDelay);
        acked = (ackDelay < TMO);
        cmd_start = 1'b1;
        cmd_write = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cmd_start = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 16'($urandom);
        expOvr = 1'b0;
        checkOutput("req_we",    bus_we,    we);
        checkOutput("req_addr",  bus_addr,  addr);
        checkOutput("req_wdata", bus_wdata, wd);
        for (int c = 0; c < nReq; c++) begin
            checkOutput("req_high", bus_req, 1'b1);
            checkOutput("req_nodone", rsp_done, 1'b0);
            if (c == extraAt) begin
                cmd_start = 1'b1;
                cmd_addr  = ~addr;
                expOvr    = 1'b1;
            end
            if (c == ackDelay) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            tick();
            cmd_start = 1'b0;
            bus_ack   = 1'b0;
            bus_rdata = 16'($urandom);
        end
        if (acked) begin
            if (!we) expRdata = rd;
            expTmo = 1'b0;
        end else begin
            expRdata = ERR;
            expTmo   = 1'b1;
        end
        checkOutput("done_pulse",  rsp_done,   1'b1);
        checkOutput("done_req",    bus_req,    1'b0);
        checkOutput("done_rdata",  rsp_rdata,  expRdata);
        checkOutput("done_status", rsp_status, expStatus(1'b1));
        checkOutput("done_addr",   bus_addr,   addr);
        if (extraAt == -2) begin
            cmd_start = 1'b1;
            expOvr    = 1'b1;
        end
        expCnt++;
        tick();
        cmd_start = 1'b0;
        checkOutput("idle_done",   rsp_done,   1'b0);
        checkOutput("idle_req",    bus_req,    1'b0);
        checkOutput("idle_rdata",  rsp_rdata,  expRdata);
        checkOutput("idle_status", rsp_status, expStatus(1'b0));
        checkOutput("idle_hold_we",    bus_we,    we);
        checkOutput("idle_hold_wdata", bus_wdata, wd);
    endtask

    task automatic idleAck();
        bus_ack   = 1'b1;
        bus_rdata = 16'($urandom);
        tick();
        bus_ack = 1'b0;
        checkOutput("stray_ack_done",  rsp_done,  1'b0);
        checkOutput("stray_ack_req",   bus_req,   1'b0);
        checkOutput("stray_ack_rdata", rsp_rdata, expRdata);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rdata"},  rsp_rdata,  16'h0);
        checkOutput({tag, "_status"}, rsp_status, 16'h0);
        checkOutput({tag, "_done"},   rsp_done,   1'b0);
        checkOutput({tag, "_req"},    bus_req,    1'b0);
        checkOutput({tag, "_we"},     bus_we,     1'b0);
        checkOutput({tag, "_addr"},   bus_addr,   8'h0);
        checkOutput({tag, "_wdata"},  bus_wdata,  16'h0);
    endtask

    task automatic randomTxn(input int maxDelay);
        int d;
        int x;
        int n;
        d = int'($urandom_range(0, maxDelay));
        n = reqCyclesFor(d);
        x = -1;
        case ($urandom_range(0, 5))
            0:       x = int'($urandom_range(0, n - 1));
            1:       x = -2;
            default: x = -1;
        endcase
        applyStimulus(1'($urandom), 8'($urandom), 16'($urandom), d, 16'($urandom), x);
        if ($urandom_range(0, 3) == 0) idleAck();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_start = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();
        checkAllZero("post_reset");

        applyStimulus(1'b0, 8'h12, 16'h0000, 3, 16'hBEEF, -1);
        applyStimulus(1'b1, 8'h05, 16'h1234, 0, 16'h5555, -1);
        checkOutput("write_keeps_rdata", rsp_rdata, 16'hBEEF);
        applyStimulus(1'b0, 8'h33, 16'h0000, TMO + 10, 16'h0000, -1);
        checkOutput("timeout_rdata", rsp_rdata, ERR);
        applyStimulus(1'b0, 8'h44, 16'h0000, TMO - 1, 16'hA5A5, -1);
        applyStimulus(1'b0, 8'h55, 16'h0000, 2, 16'h0F0F, 1);
        checkOutput("ovr_set", rsp_status[2], 1'b1);
        applyStimulus(1'b1, 8'h66, 16'hCAFE, 1, 16'h0000, -2);
        checkOutput("ovr_done_start", rsp_status[2], 1'b1);
        applyStimulus(1'b0, 8'h77, 16'h0000, 0, 16'h1111, -1);
        checkOutput("ovr_cleared", rsp_status[2], 1'b0);
        idleAck();

        for (int i = 0; i < 40; i++) randomTxn(TMO + 1);

        cmd_start = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hAB;
        cmd_wdata = 16'h9876;
        tick();
        cmd_start = 1'b0;
        tick();
        checkOutput("mid_req_high", bus_req, 1'b1);
        reset = 1'b1;
        tick();
        modelReset();
        checkAllZero("mid_reset");
        reset = 1'b0;
        tick();
        checkOutput("mid_reset_nodone", rsp_done, 1'b0);
        checkOutput("mid_reset_noreq",  bus_req,  1'b0);

        for (int i = 0; i < 257; i++) randomTxn(3);
`ifdef OK_REG_BRIDGE_TXN_COUNT_EN
        checkOutput("txn_count_wrap", rsp_status[15:8], 8'd1);
`else
        checkOutput("txn_count_off", rsp_status[15:8], 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
